bram_stream_mac: RTL and testbench

- Downstream consumer of the counter/BRAM/DSP benchmark's BRAM readback byte stream (the stream produced when ren is high).
- Multiplies each valid byte by a coefficient in a pipelined DSP product.
- Accumulates products over fixed-length frames.
- Logs each frame result into a small history BRAM that can be read back. The BRAM and DSP inference paths are exercised together in one sequential block.

---
 rtl/bram_stream_mac_pkg.sv | 18 +
 rtl/bram_stream_mac_hist.sv | 36 +++
 rtl/bram_stream_mac.sv | 150 +++++++++++++++
 tb/tb_bram_stream_mac.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_mac_pkg.sv
// Shared types and width constants for the BRAM-readback stream MAC.
package bram_stream_mac_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_COEF_W  = 18;
    localparam int PROD_W      = DEF_DATA_W + DEF_COEF_W;
    localparam int FRAME_CNT_W = 16;

    function automatic int prod_width(input int data_w, input int coef_w);
        return data_w + coef_w;
    endfunction

endpackage

// File: rtl/bram_stream_mac_hist.sv
// Frame-result history: one write port, one registered read-first read port.
module bram_stream_mac_hist #(
    parameter int AW = 4,
    parameter int DW = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          ren,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_d, rdata_q;

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (ren) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bram_stream_mac.sv
// Pipelined multiply-accumulate over fixed-length frames of a byte stream,
// logging each frame sum into a small history RAM.
module bram_stream_mac
    import bram_stream_mac_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int ACC_W     = 40,
    parameter int FRAME_LEN = 5,
    parameter int HIST_AW   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   din_valid,
    input  logic [DATA_W-1:0]      din,
    input  logic [COEF_W-1:0]      coef,
    input  logic                   hist_ren,
    input  logic [HIST_AW-1:0]     hist_raddr,
    output logic [ACC_W-1:0]       hist_dout,
    output logic [ACC_W-1:0]       acc_out,
    output logic                   acc_valid,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overflow,
    output logic                   busy
);

    localparam int PW = prod_width(DATA_W, COEF_W);

    logic [DATA_W-1:0]      din_s1_d, din_s1_q;
    logic [COEF_W-1:0]      coef_s1_d, coef_s1_q;
    logic                   v_s1_d, v_s1_q;
    logic [PW-1:0]          p_d, p_q;
    logic                   v_s2_d, v_s2_q;
    state_e                 state_d, state_q;
    logic [ACC_W-1:0]       acc_d, acc_q;
    logic [15:0]            scnt_d, scnt_q;
    logic [HIST_AW-1:0]     wptr_d, wptr_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_d, frame_cnt_q;
    logic [ACC_W-1:0]       acc_out_d, acc_out_q;
    logic                   acc_valid_d, acc_valid_q;
    logic                   ovf_d, ovf_q;

    logic [ACC_W:0]         sum;
    logic [15:0]            new_cnt;
    logic                   hist_we;

    // Stages 1 and 2 stay free of control so the DSP sees registered operands and product.
    always_comb begin
        din_s1_d  = din;
        coef_s1_d = coef;
        v_s1_d    = din_valid & ~clear;
        p_d       = PW'(din_s1_q) * PW'(coef_s1_q);
        v_s2_d    = v_s1_q & ~clear;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        scnt_d      = scnt_q;
        wptr_d      = wptr_q;
        frame_cnt_d = frame_cnt_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = 1'b0;
        ovf_d       = ovf_q;
        hist_we     = 1'b0;

        // In IDLE the sample starts a new frame, so the running sum is ignored.
        sum     = {1'b0, (state_q == ST_ACCUM) ? acc_q : '0} + (ACC_W+1)'(p_q);
        new_cnt = (state_q == ST_ACCUM) ? scnt_q + 16'd1 : 16'd1;

        if (clear) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            scnt_d      = '0;
            wptr_d      = '0;
            frame_cnt_d = '0;
            ovf_d       = 1'b0;
        end else if (v_s2_q) begin
            ovf_d = ovf_q | sum[ACC_W];
            if (new_cnt == 16'(FRAME_LEN)) begin
                acc_out_d   = sum[ACC_W-1:0];
                acc_valid_d = 1'b1;
                hist_we     = 1'b1;
                wptr_d      = wptr_q + 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
                acc_d       = '0;
                scnt_d      = '0;
                state_d     = ST_IDLE;
            end else begin
                acc_d   = sum[ACC_W-1:0];
                scnt_d  = new_cnt;
                state_d = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_s1_q    <= '0;
            coef_s1_q   <= '0;
            v_s1_q      <= 1'b0;
            p_q         <= '0;
            v_s2_q      <= 1'b0;
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            scnt_q      <= '0;
            wptr_q      <= '0;
            frame_cnt_q <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            din_s1_q    <= din_s1_d;
            coef_s1_q   <= coef_s1_d;
            v_s1_q      <= v_s1_d;
            p_q         <= p_d;
            v_s2_q      <= v_s2_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            scnt_q      <= scnt_d;
            wptr_q      <= wptr_d;
            frame_cnt_q <= frame_cnt_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    bram_stream_mac_hist #(
        .AW (HIST_AW),
        .DW (ACC_W)
    ) u_hist (
        .clk   (clk),
        .rst_n (reset),
        .we    (hist_we),
        .waddr (wptr_q),
        .wdata (acc_out_d),
        .ren   (hist_ren),
        .raddr (hist_raddr),
        .rdata (hist_dout)
    );

    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign overflow  = ovf_q;
    assign busy      = v_s1_q | v_s2_q | (state_q == ST_ACCUM);

endmodule

// File: tb/tb_bram_stream_mac.sv
// Directed bench for bram_stream_mac with a queue-based frame-result scoreboard.
module tb_bram_stream_mac;

    localparam int ACC_W = 28;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              din_valid = 1'b0;
    logic [7:0]        din = '0;
    logic [17:0]       coef = '0;
    logic              hist_ren = 1'b0;
    logic [3:0]        hist_raddr = '0;
    logic [ACC_W-1:0]  hist_dout;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic [15:0]       frame_cnt;
    logic              overflow;
    logic              busy;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    bram_stream_mac #(
        .DATA_W    (8),
        .COEF_W    (18),
        .ACC_W     (ACC_W),
        .FRAME_LEN (5),
        .HIST_AW   (4)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .clear      (clear),
        .din_valid  (din_valid),
        .din        (din),
        .coef       (coef),
        .hist_ren   (hist_ren),
        .hist_raddr (hist_raddr),
        .hist_dout  (hist_dout),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .frame_cnt  (frame_cnt),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every acc_valid pulse must match the oldest expected frame result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && acc_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_acc_valid: got acc_out %0d at cycle %0d, expected no pulse", acc_out, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("acc_out", 64'(acc_out), e.val);
                    check("acc_valid_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic send(input int d, input int c);
        @(posedge clk); #1;
        din_valid = 1'b1;
        din       = 8'(d);
        coef      = 18'(c);
    endtask

    task automatic push_exp(input logic [63:0] v);
        exp_t e;
        e.val = v;
        e.cyc = cyc + 3;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            din_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input int d, input int c, input int gap, input logic [63:0] v);
        for (int i = 0; i < 5; i++) begin
            send(d, c);
            if (i == 4) push_exp(v);
            else if (gap > 0) idle(gap);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        din_valid = 1'b0;
        clear     = 1'b1;
        @(posedge clk); #1;
        clear     = 1'b0;
    endtask

    task automatic hist_read(input int addr, input logic [63:0] v);
        @(posedge clk); #1;
        hist_ren   = 1'b1;
        hist_raddr = 4'(addr);
        @(posedge clk); #1;
        hist_ren   = 1'b0;
        check($sformatf("hist[%0d]", addr), 64'(hist_dout), v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_acc_out", 64'(acc_out), 0);
        check("rst_acc_valid", 64'(acc_valid), 0);
        check("rst_frame_cnt", 64'(frame_cnt), 0);
        check("rst_overflow", 64'(overflow), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_hist_dout", 64'(hist_dout), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Basic frame: 3*(1+2+3+4+5) = 45
        for (int i = 1; i <= 5; i++) begin
            send(i, 3);
            if (i == 5) push_exp(45);
        end
        idle(1);
        drain();
        check("basic_frame_cnt", 64'(frame_cnt), 1);
        check("basic_busy", 64'(busy), 0);
        hist_read(0, 45);

        // Gapped frame A (5*10*2=100) then back-to-back frame B (5)
        pulse_clear();
        send_frame(10, 2, 1, 100);
        send_frame(1, 1, 0, 5);
        idle(1);
        drain();
        check("ab_frame_cnt", 64'(frame_cnt), 2);
        hist_read(0, 100);
        hist_read(1, 5);

        // 17 back-to-back frames; frame 16 (sum 80) overwrites slot 0
        pulse_clear();
        for (int k = 0; k <= 16; k++) send_frame(k, 1, 0, 64'(5 * k));
        idle(1);
        drain();
        check("wrap_frame_cnt", 64'(frame_cnt), 17);
        hist_read(0, 80);
        hist_read(15, 75);
        hist_read(1, 5);
        @(posedge clk); #1;
        hist_raddr = 4'd7;
        @(posedge clk); #1;
        check("hist_hold", 64'(hist_dout), 5);

        // Overflow: 5*255*262143 = 334232325 wraps to 65796869
        pulse_clear();
        send_frame(255, 262143, 0, 65796869);
        idle(1);
        drain();
        check("ovf_flag", 64'(overflow), 1);
        send_frame(1, 1, 0, 5);
        idle(1);
        drain();
        check("ovf_sticky", 64'(overflow), 1);
        check("ovf_frame_cnt", 64'(frame_cnt), 2);

        // Clear after 3 samples of a frame discards it
        for (int i = 0; i < 3; i++) send(7, 9);
        @(posedge clk); #1;
        din_valid = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        check("mid_busy_before_clear", 64'(busy), 1);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_busy", 64'(busy), 0);
        check("clr_frame_cnt", 64'(frame_cnt), 0);
        check("clr_overflow", 64'(overflow), 0);
        check("clr_acc_out_hold", 64'(acc_out), 5);
        idle(4);
        send_frame(1, 1, 0, 5);
        idle(1);
        drain();
        check("post_clr_frame_cnt", 64'(frame_cnt), 1);
        check("post_clr_hist0", 64'(dut.u_hist.mem[0]), 5);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
